// File: rtl/fifo_read_adapter_if.sv
// Bundle between the adapter, the read side of a FIFO (pop with 1-cycle latency)
// and the downstream valid/ready stream consumer.
interface fifo_read_adapter_if #(
    parameter int FIFO_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
);
    logic                   empty;
    logic                   r_en;
    logic [FIFO_WIDTH-1:0]  data_out;
    logic                   flush;
    logic                   m_valid;
    logic [FIFO_WIDTH-1:0]  m_data;
    logic                   m_ready;
    logic [COUNT_WIDTH-1:0] rd_count;

    modport master (
        input  empty, data_out, flush, m_ready,
        output r_en, m_valid, m_data, rd_count
    );

    modport slave (
        output empty, data_out, flush, m_ready,
        input  r_en, m_valid, m_data, rd_count
    );
endinterface

// File: rtl/fifo_read_adapter.sv
// Turns a FIFO pop port with one cycle of read latency into a valid/ready stream
// through a 2-entry skid buffer; counts words accepted downstream.
//
// state | meaning
// EMPTY | no word buffered, m_valid low
// ONE   | head holds the oldest word
// TWO   | head and tail both hold words; tail is the younger one
module fifo_read_adapter #(
    parameter int FIFO_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input logic              rclk,
    input logic              rrst_n,
    fifo_read_adapter_if.master bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    occ_t                   occ;
    occ_t                   occ_nxt;
    logic                   pend;
    logic [FIFO_WIDTH-1:0]  head;
    logic [FIFO_WIDTH-1:0]  tail;
    logic [FIFO_WIDTH-1:0]  head_nxt;
    logic [FIFO_WIDTH-1:0]  tail_nxt;
    logic [COUNT_WIDTH-1:0] count;
    logic                   pop;
    logic                   capture;
    logic                   rd;
    logic [2:0]             level;

    // Occupancy after this edge, counting the word already in flight, decides
    // whether another read fits; occ + pend never exceeds two.
    always_comb begin
        pop     = (occ != EMPTY) && bus.m_ready && !bus.flush;
        capture = pend && !bus.flush;
        level   = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
        rd      = !bus.empty && !bus.flush && rrst_n && (level < 3'd2);
    end

    always_comb begin
        occ_nxt  = occ;
        head_nxt = head;
        tail_nxt = tail;
        if (bus.flush) begin
            occ_nxt = EMPTY;
        end else begin
            case (occ)
                EMPTY: begin
                    if (capture) begin
                        occ_nxt  = ONE;
                        head_nxt = bus.data_out;
                    end
                end
                ONE: begin
                    case ({capture, pop})
                        2'b10: begin
                            occ_nxt  = TWO;
                            tail_nxt = bus.data_out;
                        end
                        2'b01:   occ_nxt  = EMPTY;
                        2'b11:   head_nxt = bus.data_out;
                        default: occ_nxt  = ONE;
                    endcase
                end
                TWO: begin
                    if (pop) begin
                        head_nxt = tail;
                        if (capture) begin
                            tail_nxt = bus.data_out;
                        end else begin
                            occ_nxt = ONE;
                        end
                    end
                end
                default: occ_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ   <= EMPTY;
            pend  <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            occ   <= occ_nxt;
            pend  <= rd;
            head  <= head_nxt;
            tail  <= tail_nxt;
            if (pop) begin
                count <= count + CNT_ONE;
            end
        end
    end

    assign bus.r_en     = rd;
    assign bus.m_valid  = (occ != EMPTY);
    assign bus.m_data   = head;
    assign bus.rd_count = count;

    // A full buffer must never see a capture it cannot drain the same edge.
    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(occ == TWO && capture && !pop));

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Directed bench for fifo_read_adapter: a small FIFO model feeds the DUT and a
// negedge monitor pops expected words from a scoreboard queue on each transfer.
module tb_fifo_read_adapter;

    logic rclk = 1'b0;
    logic rrst_n;

    always #5 rclk = ~rclk;

    fifo_read_adapter_if #(.FIFO_WIDTH(16), .COUNT_WIDTH(4)) bus ();

    fifo_read_adapter #(.FIFO_WIDTH(16), .COUNT_WIDTH(4)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    // FIFO model: words written by stimulus, popped with one cycle of latency.
    logic [15:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign bus.empty = (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (bus.r_en && (wr_ptr != rd_ptr)) begin
            bus.data_out <= mem[rd_ptr % 64];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input bit expect_it);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
        if (expect_it) exp_q.push_back(w);
    endtask

    task automatic window(input int n, output int ren_cnt, output int first_ren,
                          output int first_v, output int last_v, output int v_cnt);
        ren_cnt = 0; v_cnt = 0; first_ren = -1; first_v = -1; last_v = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge rclk);
            if (bus.r_en) begin
                ren_cnt++;
                if (first_ren < 0) first_ren = i;
            end
            if (bus.m_valid) begin
                v_cnt++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
    endtask

    // Monitor: underflow, stall stability, and in-order delivery.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    always @(negedge rclk) begin
        if (bus.empty) check("no_underflow", {31'd0, bus.r_en}, 32'd0);
        if (rrst_n && !bus.flush && prev_stall) begin
            check("stall_valid", {31'd0, bus.m_valid}, 32'd1);
            check("stall_data", {16'd0, bus.m_data}, {16'd0, prev_data});
        end
        if (rrst_n && !bus.flush && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_extra: got %0h expected no word", bus.m_data);
            end else begin
                check("stream_data", {16'd0, bus.m_data}, {16'd0, exp_q.pop_front()});
            end
        end
        prev_stall = rrst_n && !bus.flush && bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc, fr, fv, lv, vc;
        rrst_n       = 1'b0;
        bus.flush    = 1'b0;
        bus.m_ready  = 1'b0;
        #2;
        check("rst_r_en", {31'd0, bus.r_en}, 32'd0);
        check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rst_m_data", {16'd0, bus.m_data}, 32'd0);
        check("rst_rd_count", {28'd0, bus.rd_count}, 32'd0);
        step();
        step();
        rrst_n = 1'b1;
        step();

        // Streaming: 8 words, full throughput.
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(16'h00A1 + 16'(i), 1'b1);
        window(14, rc, fr, fv, lv, vc);
        check("stream_ren_cnt", rc, 8);
        check("stream_latency", fv - fr, 2);
        check("stream_valid_cnt", vc, 8);
        check("stream_no_gap", lv - fv, 7);
        check("stream_rd_count", {28'd0, bus.rd_count}, 32'd8);

        // Backpressure: only two reads fit the skid buffer.
        step();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(16'h00B1 + 16'(i), 1'b1);
        window(6, rc, fr, fv, lv, vc);
        check("bp_ren_cnt", rc, 2);
        check("bp_valid", {31'd0, bus.m_valid}, 32'd1);
        check("bp_head", {16'd0, bus.m_data}, 32'h00B1);
        step();
        bus.m_ready = 1'b1;
        window(10, rc, fr, fv, lv, vc);
        check("bp_first_valid", fv, 0);
        check("bp_valid_cnt", vc, 5);
        check("bp_no_gap", lv - fv, 4);
        check("bp_rd_count", {28'd0, bus.rd_count}, 32'd13);

        // Empty boundary: one word, one read.
        step();
        push(16'h00C1, 1'b1);
        window(6, rc, fr, fv, lv, vc);
        check("one_ren_cnt", rc, 1);
        check("one_valid_cnt", vc, 1);
        check("one_valid_drop", {31'd0, bus.m_valid}, 32'd0);
        check("one_rd_count", {28'd0, bus.rd_count}, 32'd14);

        // Flush with D1 buffered and D2 in flight; only D3 survives.
        step();
        bus.m_ready = 1'b0;
        push(16'h00D1, 1'b0);
        push(16'h00D2, 1'b0);
        push(16'h00D3, 1'b1);
        step();
        step();
        check("fl_pre_valid", {31'd0, bus.m_valid}, 32'd1);
        check("fl_pre_head", {16'd0, bus.m_data}, 32'h00D1);
        bus.flush   = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check("fl_r_en_blocked", {31'd0, bus.r_en}, 32'd0);
        step();
        bus.flush = 1'b0;
        check("fl_valid_cleared", {31'd0, bus.m_valid}, 32'd0);
        check("fl_rd_count_held", {28'd0, bus.rd_count}, 32'd14);
        window(8, rc, fr, fv, lv, vc);
        check("fl_valid_cnt", vc, 1);
        check("fl_rd_count", {28'd0, bus.rd_count}, 32'd15);

        // Asynchronous reset while two words sit in the buffer.
        step();
        bus.m_ready = 1'b0;
        push(16'h00F1, 1'b0);
        push(16'h00F2, 1'b0);
        push(16'h00F3, 1'b1);
        push(16'h00F4, 1'b1);
        step();
        step();
        step();
        check("rs_pre_valid", {31'd0, bus.m_valid}, 32'd1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("rs_async_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rs_async_r_en", {31'd0, bus.r_en}, 32'd0);
        check("rs_async_count", {28'd0, bus.rd_count}, 32'd0);
        step();
        step();
        rrst_n      = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check("rs_first_r_en", {31'd0, bus.r_en}, 32'd1);
        window(8, rc, fr, fv, lv, vc);
        check("rs_valid_cnt", vc, 2);
        check("rs_rd_count", {28'd0, bus.rd_count}, 32'd2);

        // Counter wrap: 17 transfers on a 4-bit counter.
        step();
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
        check("wr_count_zero", {28'd0, bus.rd_count}, 32'd0);
        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i), 1'b1);
        window(24, rc, fr, fv, lv, vc);
        check("wr_valid_cnt", vc, 17);
        check("wr_rd_count", {28'd0, bus.rd_count}, 32'd1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
